sync_fifo_dp_ram: RTL and testbench

Parametrised synchronous FIFO built on a generic dual-port RAM with a registered read port. It generalises the fixed 16x8 dual-port RAM to DATA_W x 2**ADDR_W storage. It adds internal read and write pointers, an occupancy count, full/empty and programmable almost flags, and overflow/underflow error pulses. It is used as the standard buffering element between producer and consumer logic in the same clock domain.

---
 rtl/sync_fifo_dp_ram_pkg.sv | 13 +
 rtl/dp_ram_param.sv | 42 ++++
 rtl/sync_fifo_dp_ram.sv | 105 ++++++++++
 tb/tb_sync_fifo_dp_ram.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/sync_fifo_dp_ram_pkg.sv
// Shared FIFO sizing: default widths and the depth computation.
// Latency: n/a (constants only). Backpressure: n/a.
// Imported by the FIFO top and its RAM so both agree on the array depth.
package sync_fifo_dp_ram_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 4;

    function automatic int fifo_depth(input int addr_w);
        return 1 << addr_w;
    endfunction

endpackage

// File: rtl/dp_ram_param.sv
// Simple dual-port RAM: one write port, one registered read port, read-before-write.
// Latency: 1 cycle from re to data_out. Backpressure: none, every request is performed.
// The array is never reset; only the read register clears to 0.
module dp_ram_param
    import sync_fifo_dp_ram_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] w_add,
    input  logic [DATA_W-1:0] data_in,
    input  logic              re,
    input  logic [ADDR_W-1:0] r_add,
    output logic [DATA_W-1:0] data_out
);

    localparam int DEPTH = fifo_depth(ADDR_W);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] data_out_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[w_add] <= data_in;
        end
    end

    // Non-blocking read of the same array gives the old word on a same-address collision.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_out_q <= '0;
        end else if (re) begin
            data_out_q <= mem_q[r_add];
        end
    end

    assign data_out = data_out_q;

endmodule

// File: rtl/sync_fifo_dp_ram.sv
// Synchronous FIFO over dp_ram_param with count, full/empty, almost flags and error pulses.
// Latency: read data valid 1 cycle after an accepted re. Backpressure: writes rejected when
// full unless a read is accepted the same cycle; reads rejected when empty (no fall-through).
module sync_fifo_dp_ram
    import sync_fifo_dp_ram_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int AFULL_TH  = 12,
    parameter int AEMPTY_TH = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic              re,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              underflow
);

    localparam int                CNT_W    = ADDR_W + 1;
    localparam logic [CNT_W-1:0]  DEPTH_C  = CNT_W'(fifo_depth(ADDR_W));
    localparam logic [CNT_W-1:0]  AFULL_C  = CNT_W'(AFULL_TH);
    localparam logic [CNT_W-1:0]  AEMPTY_C = CNT_W'(AEMPTY_TH);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;
    logic              wr_acc, rd_acc;
    logic              ram_we;

    assign full         = (count_q == DEPTH_C);
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= AFULL_C);
    assign almost_empty = (count_q <= AEMPTY_C);

    always_comb begin
        rd_acc      = re & ~empty;
        wr_acc      = we & (~full | rd_acc);
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = we & ~wr_acc;
        underflow_d = re & ~rd_acc;
        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (rd_acc) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // A write coinciding with reset must not land in the array.
    assign ram_we = wr_acc & ~reset;

    dp_ram_param #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk      (clk),
        .reset    (reset),
        .we       (ram_we),
        .w_add    (wr_ptr_q),
        .data_in  (data_in),
        .re       (rd_acc),
        .r_add    (rd_ptr_q),
        .data_out (data_out)
    );

    assign count     = count_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule

// File: tb/tb_sync_fifo_dp_ram.sv
// Scoreboard bench for sync_fifo_dp_ram at DATA_W=8, ADDR_W=4, AFULL_TH=12, AEMPTY_TH=2.
module tb_sync_fifo_dp_ram;

    logic       clk = 1'b0;
    logic       reset;
    logic       we;
    logic       re;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic       almost_empty;
    logic [4:0] count;
    logic       overflow;
    logic       underflow;

    int         n_cmp = 0;
    int         n_err = 0;
    logic [7:0] model_q [$];
    logic [7:0] exp_q [$];
    logic [7:0] exp_dout;
    logic       exp_ov;
    logic       exp_un;

    sync_fifo_dp_ram #(
        .DATA_W    (8),
        .ADDR_W    (4),
        .AFULL_TH  (12),
        .AEMPTY_TH (2)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .we           (we),
        .re           (re),
        .data_in      (data_in),
        .data_out     (data_out),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock: drive at the falling edge, update the model at the rising edge, check at the next falling edge.
    task automatic step(input logic w, input logic r, input logic [7:0] d, input logic rst);
        int   sz;
        logic wacc;
        logic racc;
        sz   = model_q.size();
        racc = r && (sz != 0) && !rst;
        wacc = w && ((sz != 16) || (r && (sz != 0))) && !rst;
        we      = w;
        re      = r;
        data_in = d;
        reset   = rst;
        if (racc) exp_q.push_back(model_q[0]);
        @(posedge clk);
        if (rst) begin
            model_q.delete();
            exp_q.delete();
            exp_dout = 8'h00;
            exp_ov   = 1'b0;
            exp_un   = 1'b0;
        end else begin
            if (racc) void'(model_q.pop_front());
            if (wacc) model_q.push_back(d);
            exp_ov = w && !wacc;
            exp_un = r && !racc;
        end
        @(negedge clk);
        if (racc) begin
            exp_dout = exp_q.pop_front();
            chk("read_data", 32'(data_out), 32'(exp_dout));
        end else begin
            chk("dout_hold", 32'(data_out), 32'(exp_dout));
        end
        sz = model_q.size();
        chk("count", 32'(count), 32'(sz));
        chk("empty", 32'(empty), 32'(sz == 0));
        chk("full", 32'(full), 32'(sz == 16));
        chk("almost_full", 32'(almost_full), 32'(sz >= 12));
        chk("almost_empty", 32'(almost_empty), 32'(sz <= 2));
        chk("overflow", 32'(overflow), 32'(exp_ov));
        chk("underflow", 32'(underflow), 32'(exp_un));
    endtask

    initial begin
        we       = 1'b0;
        re       = 1'b0;
        data_in  = 8'h00;
        reset    = 1'b1;
        exp_dout = 8'h00;
        exp_ov   = 1'b0;
        exp_un   = 1'b0;

        // reset then idle
        step(1'b0, 1'b0, 8'h00, 1'b1);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        step(1'b0, 1'b0, 8'h00, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b0);

        // fill 16 then drain in order
        for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 8'(8'h10 + i), 1'b0);
        for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 8'h00, 1'b0);

        // write while full is rejected and never read back
        for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 8'(8'h20 + i), 1'b0);
        step(1'b1, 1'b0, 8'hAA, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 8'h00, 1'b0);

        // read+write while empty: read rejected, write lands
        step(1'b1, 1'b1, 8'h55, 1'b0);
        step(1'b0, 1'b1, 8'h00, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b0);
        step(1'b0, 1'b1, 8'h00, 1'b0);

        // read+write while full: same-address collision returns the old word
        for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 8'(8'h60 + i), 1'b0);
        step(1'b1, 1'b1, 8'hC3, 1'b0);
        for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 8'h00, 1'b0);

        // reset with a concurrent write discards it
        for (int i = 0; i < 9; i++) step(1'b1, 1'b0, 8'(8'h70 + i), 1'b0);
        step(1'b1, 1'b0, 8'hEE, 1'b1);
        step(1'b1, 1'b0, 8'h3C, 1'b0);
        step(1'b0, 1'b1, 8'h00, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b0);

        // random traffic, write-biased then read-biased phases
        for (int i = 0; i < 150; i++)
            step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0), 8'($urandom), 1'b0);
        for (int i = 0; i < 150; i++)
            step(1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 3) != 0), 8'($urandom), 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
